// File: rtl/mux_decoded_pipelined.sv
// rtl/mux_decoded_pipelined.sv - decoded-select way mux with priority, quality flags and a registered valid/ready output stage
// A saturating counter tallies accepted multi-hot selects for debug.
module mux_decoded_pipelined #(
  parameter int NUMBER_WAY                = 8,
  parameter int SINGLE_ENTRY_SIZE_IN_BITS = 32,
  parameter int INDEX_WIDTH               = 4,
  parameter int PRIORITY_HIGH             = 0,
  parameter int COUNT_WIDTH               = 8
) (
  input  logic                                            clk_in,
  input  logic                                            reset_in,
  input  logic [SINGLE_ENTRY_SIZE_IN_BITS*NUMBER_WAY-1:0] way_flatted_in,
  input  logic [NUMBER_WAY-1:0]                           sel_in,
  input  logic                                            valid_in,
  output logic                                            ready_out,
  output logic [SINGLE_ENTRY_SIZE_IN_BITS-1:0]            way_flatted_out,
  output logic [INDEX_WIDTH-1:0]                          sel_index_out,
  output logic                                            valid_out,
  input  logic                                            ready_in,
  output logic                                            multi_hot_out,
  output logic                                            none_selected_out,
  output logic [COUNT_WIDTH-1:0]                          multi_hot_count_out,
  input  logic                                            count_clear_in
);

  localparam int W = SINGLE_ENTRY_SIZE_IN_BITS;
  localparam logic [NUMBER_WAY-1:0]  SEL_ONE   = NUMBER_WAY'(1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  logic [INDEX_WIDTH-1:0] sel_index;
  logic [W-1:0]           sel_data;
  logic                   found;
  logic                   multi_hot;
  logic                   accept;
  int                     k;

  // Scan in priority order; the first set bit met wins.
  always_comb begin
    sel_index = '0;
    sel_data  = '0;
    found     = 1'b0;
    k         = 0;
    for (int i = 0; i < NUMBER_WAY; i++) begin
      k = (PRIORITY_HIGH != 0) ? (NUMBER_WAY - 1 - i) : i;
      if (sel_in[k] && !found) begin
        found     = 1'b1;
        sel_index = INDEX_WIDTH'(k);
        sel_data  = way_flatted_in[k*W +: W];
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_hot = |(sel_in & (sel_in - SEL_ONE));
  assign ready_out = ~valid_out | ready_in;
  assign accept    = valid_in & ready_out;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_out           <= 1'b0;
      way_flatted_out     <= '0;
      sel_index_out       <= '0;
      multi_hot_out       <= 1'b0;
      none_selected_out   <= 1'b0;
      multi_hot_count_out <= '0;
    end else begin
      if (accept) begin
        valid_out         <= 1'b1;
        way_flatted_out   <= sel_data;
        sel_index_out     <= sel_index;
        multi_hot_out     <= multi_hot;
        none_selected_out <= ~found;
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end

      if (count_clear_in) begin
        multi_hot_count_out <= '0;
      end else if (accept && multi_hot && (multi_hot_count_out != COUNT_MAX)) begin
        multi_hot_count_out <= multi_hot_count_out + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mux_decoded_pipelined.sv
// tb/tb_mux_decoded_pipelined.sv - directed bench for mux_decoded_pipelined, low- and high-priority instances
module tb_mux_decoded_pipelined;

  logic         clk;
  logic         reset_in;
  logic [255:0] way_flatted_in;
  logic [7:0]   sel_in;
  logic         valid_in;
  logic         ready_in;
  logic         count_clear_in;

  logic         lo_ready, lo_valid, lo_multi, lo_none;
  logic [31:0]  lo_data;
  logic [3:0]   lo_idx;
  logic [7:0]   lo_cnt;

  logic         hi_ready, hi_valid, hi_multi, hi_none;
  logic [31:0]  hi_data;
  logic [3:0]   hi_idx;
  logic [1:0]   hi_cnt;

  int errors = 0;
  int checks = 0;

  mux_decoded_pipelined #(
    .NUMBER_WAY(8), .SINGLE_ENTRY_SIZE_IN_BITS(32), .INDEX_WIDTH(4),
    .PRIORITY_HIGH(0), .COUNT_WIDTH(8)
  ) dut_lo (
    .clk_in(clk), .reset_in(reset_in), .way_flatted_in(way_flatted_in),
    .sel_in(sel_in), .valid_in(valid_in), .ready_out(lo_ready),
    .way_flatted_out(lo_data), .sel_index_out(lo_idx), .valid_out(lo_valid),
    .ready_in(ready_in), .multi_hot_out(lo_multi), .none_selected_out(lo_none),
    .multi_hot_count_out(lo_cnt), .count_clear_in(count_clear_in)
  );

  mux_decoded_pipelined #(
    .NUMBER_WAY(8), .SINGLE_ENTRY_SIZE_IN_BITS(32), .INDEX_WIDTH(4),
    .PRIORITY_HIGH(1), .COUNT_WIDTH(2)
  ) dut_hi (
    .clk_in(clk), .reset_in(reset_in), .way_flatted_in(way_flatted_in),
    .sel_in(sel_in), .valid_in(valid_in), .ready_out(hi_ready),
    .way_flatted_out(hi_data), .sel_index_out(hi_idx), .valid_out(hi_valid),
    .ready_in(ready_in), .multi_hot_out(hi_multi), .none_selected_out(hi_none),
    .multi_hot_count_out(hi_cnt), .count_clear_in(count_clear_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {valid, multi, none, idx, data}
  task automatic test_reset();
    reset_in = 1'b1; valid_in = 1'b1; sel_in = 8'h01; ready_in = 1'b1; count_clear_in = 1'b0;
    tick();
    tick();
    checks++;
    if ({lo_valid, lo_multi, lo_none, lo_idx, lo_data, lo_cnt} !== 47'd0) begin
      errors++;
      $display("FAIL reset_lo: got v=%b m=%b n=%b idx=%0d data=%h cnt=%0d, need all 0",
               lo_valid, lo_multi, lo_none, lo_idx, lo_data, lo_cnt);
    end
    checks++;
    if ({hi_valid, hi_multi, hi_none, hi_idx, hi_data, hi_cnt} !== 41'd0) begin
      errors++;
      $display("FAIL reset_hi: got v=%b m=%b n=%b idx=%0d data=%h cnt=%0d, need all 0",
               hi_valid, hi_multi, hi_none, hi_idx, hi_data, hi_cnt);
    end
    reset_in = 1'b0; valid_in = 1'b0;
    #1;
    checks++;
    if ({lo_ready, hi_ready} !== 2'b11) begin
      errors++;
      $display("FAIL reset_ready: got lo=%b hi=%b, need 1 1", lo_ready, hi_ready);
    end
  endtask

  task automatic test_onehot_sweep();
    ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel_in = 8'(1 << i); valid_in = 1'b1;
      tick();
      checks++;
      if ({lo_valid, lo_multi, lo_none, lo_idx, lo_data} !== {3'b100, 4'(i), 32'hA0 + 32'(i)}) begin
        errors++;
        $display("FAIL sweep_lo[%0d]: got v=%b m=%b n=%b idx=%0d data=%h, need v=1 m=0 n=0 idx=%0d data=%h",
                 i, lo_valid, lo_multi, lo_none, lo_idx, lo_data, i, 32'hA0 + 32'(i));
      end
      checks++;
      if ({hi_valid, hi_multi, hi_none, hi_idx, hi_data} !== {3'b100, 4'(i), 32'hA0 + 32'(i)}) begin
        errors++;
        $display("FAIL sweep_hi[%0d]: got v=%b m=%b n=%b idx=%0d data=%h, need v=1 m=0 n=0 idx=%0d data=%h",
                 i, hi_valid, hi_multi, hi_none, hi_idx, hi_data, i, 32'hA0 + 32'(i));
      end
    end
    valid_in = 1'b0;
    tick();
    checks++;
    if ({lo_valid, hi_valid} !== 2'b00) begin
      errors++;
      $display("FAIL sweep_drain: got lo=%b hi=%b, need 0 0", lo_valid, hi_valid);
    end
  endtask

  task automatic test_priority_multi();
    sel_in = 8'b0010_0100; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    checks++;
    if ({lo_valid, lo_multi, lo_none, lo_idx, lo_data, lo_cnt} !== {3'b110, 4'd2, 32'hA2, 8'd1}) begin
      errors++;
      $display("FAIL prio_lo: got v=%b m=%b n=%b idx=%0d data=%h cnt=%0d, need v=1 m=1 n=0 idx=2 data=a2 cnt=1",
               lo_valid, lo_multi, lo_none, lo_idx, lo_data, lo_cnt);
    end
    checks++;
    if ({hi_valid, hi_multi, hi_none, hi_idx, hi_data, hi_cnt} !== {3'b110, 4'd5, 32'hA5, 2'd1}) begin
      errors++;
      $display("FAIL prio_hi: got v=%b m=%b n=%b idx=%0d data=%h cnt=%0d, need v=1 m=1 n=0 idx=5 data=a5 cnt=1",
               hi_valid, hi_multi, hi_none, hi_idx, hi_data, hi_cnt);
    end
    tick();
  endtask

  task automatic test_empty_select();
    sel_in = 8'h00; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    valid_in = 1'b0;
    checks++;
    if ({lo_valid, lo_multi, lo_none, lo_idx, lo_data} !== {3'b101, 4'd0, 32'h0}) begin
      errors++;
      $display("FAIL empty_lo: got v=%b m=%b n=%b idx=%0d data=%h, need v=1 m=0 n=1 idx=0 data=0",
               lo_valid, lo_multi, lo_none, lo_idx, lo_data);
    end
    checks++;
    if ({hi_valid, hi_multi, hi_none, hi_idx, hi_data} !== {3'b101, 4'd0, 32'h0}) begin
      errors++;
      $display("FAIL empty_hi: got v=%b m=%b n=%b idx=%0d data=%h, need v=1 m=0 n=1 idx=0 data=0",
               hi_valid, hi_multi, hi_none, hi_idx, hi_data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    sel_in = 8'h08; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    sel_in = 8'h10; ready_in = 1'b0;
    #1;
    checks++;
    if ({lo_valid, lo_idx, lo_ready} !== {1'b1, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL bp_first: got v=%b idx=%0d rdy=%b, need v=1 idx=3 rdy=0", lo_valid, lo_idx, lo_ready);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({lo_valid, lo_idx, lo_data, lo_ready, hi_idx} !== {1'b1, 4'd3, 32'hA3, 1'b0, 4'd3}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b idx=%0d data=%h rdy=%b hi_idx=%0d, need v=1 idx=3 data=a3 rdy=0 hi_idx=3",
                 c, lo_valid, lo_idx, lo_data, lo_ready, hi_idx);
      end
    end
    ready_in = 1'b1;
    #1;
    checks++;
    if (lo_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: got %b, need 1", lo_ready);
    end
    tick();
    valid_in = 1'b0;
    checks++;
    if ({lo_valid, lo_idx, lo_data} !== {1'b1, 4'd4, 32'hA4}) begin
      errors++;
      $display("FAIL bp_reload: got v=%b idx=%0d data=%h, need v=1 idx=4 data=a4", lo_valid, lo_idx, lo_data);
    end
    tick();
    checks++;
    if ({lo_valid, hi_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_no_dup: got lo=%b hi=%b, need 0 0", lo_valid, hi_valid);
    end
  endtask

  task automatic test_counter_saturation();
    count_clear_in = 1'b1; valid_in = 1'b0;
    tick();
    count_clear_in = 1'b0;
    checks++;
    if ({lo_cnt, hi_cnt} !== 10'd0) begin
      errors++;
      $display("FAIL cnt_clear_idle: got lo=%0d hi=%0d, need 0 0", lo_cnt, hi_cnt);
    end
    sel_in = 8'h03; valid_in = 1'b1; ready_in = 1'b1;
    for (int n = 0; n < 5; n++) tick();
    checks++;
    if ({lo_cnt, hi_cnt} !== {8'd5, 2'd3}) begin
      errors++;
      $display("FAIL cnt_saturate: got lo=%0d hi=%0d, need 5 3", lo_cnt, hi_cnt);
    end
    checks++;
    if ({hi_idx, hi_data, lo_idx, lo_data} !== {4'd1, 32'hA1, 4'd0, 32'hA0}) begin
      errors++;
      $display("FAIL cnt_sel: got hi_idx=%0d hi_data=%h lo_idx=%0d lo_data=%h, need 1 a1 0 a0",
               hi_idx, hi_data, lo_idx, lo_data);
    end
    count_clear_in = 1'b1;
    tick();
    count_clear_in = 1'b0; valid_in = 1'b0;
    checks++;
    if ({lo_cnt, hi_cnt, lo_valid, lo_multi} !== {8'd0, 2'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL cnt_clear_prio: got lo=%0d hi=%0d v=%b m=%b, need 0 0 1 1", lo_cnt, hi_cnt, lo_valid, lo_multi);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) way_flatted_in[i*32 +: 32] = 32'hA0 + 32'(i);
    test_reset();
    test_onehot_sweep();
    test_priority_multi();
    test_empty_select();
    test_backpressure();
    test_counter_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
